// File: rtl/lsb_mem_ctrl.sv
// lsb_mem_ctrl: serialises one LSB load/store request at a time onto the byte-wide RAM/IO bus.
// Define LSB_MEM_CTRL_IO_STALL_EN to hold IO-space writes while the UART buffer is full.
module lsb_mem_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int VAL_WIDTH    = 32,
    parameter int LSB_ID_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush,
    input  logic                    lsb2mem_load_en,
    input  logic                    lsb2mem_store_en,
    input  logic [ADDR_WIDTH-1:0]   lsb2mem_addr,
    input  logic [2:0]              lsb2mem_type,
    input  logic [VAL_WIDTH-1:0]    lsb2mem_val,
    input  logic [LSB_ID_WIDTH-1:0] lsb2mem_load_id,
    output logic                    mem_busy,
    output logic                    mem2lsb_load_en,
    output logic [LSB_ID_WIDTH-1:0] mem2lsb_load_id,
    output logic [VAL_WIDTH-1:0]    mem2lsb_load_val,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [ADDR_WIDTH-1:0]   mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
`ifdef LSB_MEM_CTRL_IO_STALL_EN
        , IO_WAIT
`endif
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [2:0]              kind;
    logic [VAL_WIDTH-1:0]    wdata;
    logic [LSB_ID_WIDTH-1:0] id;
    logic [2:0]              idx;
    logic [2:0]              cnt;
    logic                    rd_expect;
    logic [VAL_WIDTH-1:0]    rdata;
    logic                    pend_valid;
    logic [ADDR_WIDTH-1:0]   pend_addr;
    logic [2:0]              pend_type;
    logic [VAL_WIDTH-1:0]    pend_val;
    logic                    rdy_q;
    logic                    load_en_q;
    logic                    wr_q;

    logic [2:0]              size;
    logic [2:0]              cnt_next;
    logic [VAL_WIDTH-1:0]    merged;
    logic                    stall;
    logic [ADDR_WIDTH-1:0]   st_addr;
    logic [2:0]              st_type;
    logic [VAL_WIDTH-1:0]    st_val;

    function automatic logic [VAL_WIDTH-1:0] extend(input logic [2:0] t, input logic [VAL_WIDTH-1:0] d);
        case (t)
            3'b000:  extend = {{(VAL_WIDTH-8){d[7]}}, d[7:0]};
            3'b001:  extend = {{(VAL_WIDTH-16){d[15]}}, d[15:0]};
            3'b100:  extend = {{(VAL_WIDTH-8){1'b0}}, d[7:0]};
            3'b101:  extend = {{(VAL_WIDTH-16){1'b0}}, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    always_comb begin
        case (kind[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;
        endcase
    end

    always_comb begin
        merged = rdata;
        merged[{cnt[1:0], 3'b000} +: 8] = mem_din;
    end

    assign cnt_next = cnt + {2'b00, rd_expect};

`ifdef LSB_MEM_CTRL_IO_STALL_EN
    assign stall = (state == WRITE || state == IO_WAIT) && (mem_a[17:16] == 2'b11) && io_buffer_full;
`else
    logic unused_io_full;
    assign unused_io_full = io_buffer_full;
    assign stall          = 1'b0;
`endif

    // A latched store always starts before a newly arriving one.
    assign st_addr = pend_valid ? pend_addr : lsb2mem_addr;
    assign st_type = pend_valid ? pend_type : lsb2mem_type;
    assign st_val  = pend_valid ? pend_val  : lsb2mem_val;

    assign mem_busy        = (state != IDLE) | pend_valid;
    assign mem_wr          = wr_q & rdy_in & ~stall;
    assign mem2lsb_load_en = load_en_q & rdy_in & ~flush;

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state            <= IDLE;
            addr             <= '0;
            kind             <= '0;
            wdata            <= '0;
            id               <= '0;
            idx              <= '0;
            cnt              <= '0;
            rd_expect        <= 1'b0;
            rdata            <= '0;
            pend_valid       <= 1'b0;
            pend_addr        <= '0;
            pend_type        <= '0;
            pend_val         <= '0;
            rdy_q            <= 1'b0;
            load_en_q        <= 1'b0;
            wr_q             <= 1'b0;
            mem2lsb_load_id  <= '0;
            mem2lsb_load_val <= '0;
            mem_a            <= '0;
            mem_dout         <= '0;
        end else begin
            rdy_q <= rdy_in;
            if (rdy_in) begin
                load_en_q <= 1'b0;
                if (state == IDLE && pend_valid)
                    pend_valid <= 1'b0;
                if (lsb2mem_store_en && (state != IDLE || pend_valid)) begin
                    pend_valid <= 1'b1;
                    pend_addr  <= lsb2mem_addr;
                    pend_type  <= lsb2mem_type;
                    pend_val   <= lsb2mem_val;
                end

                case (state)
                    IDLE: begin
                        if (pend_valid || lsb2mem_store_en) begin
                            state    <= WRITE;
                            addr     <= st_addr;
                            kind     <= st_type;
                            wdata    <= st_val;
                            mem_a    <= st_addr;
                            mem_dout <= st_val[7:0];
                            wr_q     <= 1'b1;
                            idx      <= 3'd1;
                        end else if (lsb2mem_load_en && !flush) begin
                            state     <= READ;
                            addr      <= lsb2mem_addr;
                            kind      <= lsb2mem_type;
                            id        <= lsb2mem_load_id;
                            mem_a     <= lsb2mem_addr;
                            wr_q      <= 1'b0;
                            idx       <= 3'd1;
                            cnt       <= 3'd0;
                            rd_expect <= 1'b0;
                            rdata     <= '0;
                        end
                    end

                    READ: begin
                        if (flush) begin
                            state     <= IDLE;
                            rd_expect <= 1'b0;
                        end else if (!rdy_q) begin
                            // The byte in flight during the freeze was lost; re-issue the first missing one.
                            mem_a     <= addr + ADDR_WIDTH'(cnt);
                            idx       <= cnt + 3'd1;
                            rd_expect <= 1'b0;
                        end else begin
                            if (rd_expect) begin
                                rdata <= merged;
                                cnt   <= cnt_next;
                            end
                            if (cnt_next == size) begin
                                state            <= IDLE;
                                rd_expect        <= 1'b0;
                                load_en_q        <= 1'b1;
                                mem2lsb_load_id  <= id;
                                mem2lsb_load_val <= extend(kind, merged);
                            end else begin
                                rd_expect <= (idx > cnt_next);
                                if (idx < size) begin
                                    mem_a <= addr + ADDR_WIDTH'(idx);
                                    idx   <= idx + 3'd1;
                                end
                            end
                        end
                    end

                    default: begin
                        if (stall) begin
`ifdef LSB_MEM_CTRL_IO_STALL_EN
                            state <= IO_WAIT;
`endif
                        end else if (idx < size) begin
                            state    <= WRITE;
                            mem_a    <= addr + ADDR_WIDTH'(idx);
                            mem_dout <= wdata[{idx[1:0], 3'b000} +: 8];
                            idx      <= idx + 3'd1;
                        end else begin
                            state <= IDLE;
                            wr_q  <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lsb_mem_ctrl.sv
// Directed bench for lsb_mem_ctrl: byte-bus RAM model with a fixed content table.
// IO-stall checks follow LSB_MEM_CTRL_IO_STALL_EN when it is defined for the build.
module tb_lsb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        lsb2mem_load_en;
    logic        lsb2mem_store_en;
    logic [31:0] lsb2mem_addr;
    logic [2:0]  lsb2mem_type;
    logic [31:0] lsb2mem_val;
    logic [2:0]  lsb2mem_load_id;
    logic        mem_busy;
    logic        mem2lsb_load_en;
    logic [2:0]  mem2lsb_load_id;
    logic [31:0] mem2lsb_load_val;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    localparam logic [2:0] T_B = 3'b000, T_H = 3'b001, T_W = 3'b010, T_BU = 3'b100, T_HU = 3'b101;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    lsb_mem_ctrl #(.ADDR_WIDTH(32), .VAL_WIDTH(32), .LSB_ID_WIDTH(3)) dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .lsb2mem_load_en(lsb2mem_load_en), .lsb2mem_store_en(lsb2mem_store_en),
        .lsb2mem_addr(lsb2mem_addr), .lsb2mem_type(lsb2mem_type), .lsb2mem_val(lsb2mem_val),
        .lsb2mem_load_id(lsb2mem_load_id), .mem_busy(mem_busy),
        .mem2lsb_load_en(mem2lsb_load_en), .mem2lsb_load_id(mem2lsb_load_id),
        .mem2lsb_load_val(mem2lsb_load_val), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h100: return 8'h11;
            32'h101: return 8'h22;
            32'h102: return 8'h33;
            32'h103: return 8'h44;
            32'h005: return 8'h80;
            32'h006: return 8'h34;
            32'h007: return 8'h92;
            default: return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    always @(posedge clk) mem_din <= rom(mem_a);

    always @(posedge clk) begin
        if (rst_in) begin
            assert (!(lsb2mem_load_en && lsb2mem_store_en)) else $error("both strobes asserted");
            assert (!(lsb2mem_store_en && dut.pend_valid)) else $error("store while slot full");
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_load(input logic [31:0] a, input logic [2:0] t, input logic [2:0] lid);
        lsb2mem_load_en = 1'b1;
        lsb2mem_addr    = a;
        lsb2mem_type    = t;
        lsb2mem_load_id = lid;
        step();
        lsb2mem_load_en = 1'b0;
    endtask

    task automatic send_store(input logic [31:0] a, input logic [2:0] t, input logic [31:0] v);
        lsb2mem_store_en = 1'b1;
        lsb2mem_addr     = a;
        lsb2mem_type     = t;
        lsb2mem_val      = v;
        step();
        lsb2mem_store_en = 1'b0;
    endtask

    // Entered in cycle E+1; checks address phase, then the pulse at E+n+2.
    task automatic expect_load(input logic [31:0] a, input int n, input logic [2:0] lid, input logic [31:0] v);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("rd_addr", mem_a, a + 32'(k));
            check("rd_wr", {31'b0, mem_wr}, 32'd0);
            step();
        end
        @(negedge clk);
        check("rd_early", {31'b0, mem2lsb_load_en}, 32'd0);
        check("rd_busy", {31'b0, mem_busy}, 32'd1);
        step();
        @(negedge clk);
        check("rd_pulse", {31'b0, mem2lsb_load_en}, 32'd1);
        check("rd_id", {29'b0, mem2lsb_load_id}, {29'b0, lid});
        check("rd_val", mem2lsb_load_val, v);
        check("rd_idle", {31'b0, mem_busy}, 32'd0);
        step();
        @(negedge clk);
        check("rd_pulse_end", {31'b0, mem2lsb_load_en}, 32'd0);
    endtask

    task automatic expect_store(input logic [31:0] a, input int n, input logic [31:0] v);
        logic [31:0] d;
        d = v;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("wr_en", {31'b0, mem_wr}, 32'd1);
            check("wr_addr", mem_a, a + 32'(k));
            check("wr_byte", {24'b0, mem_dout}, {24'b0, d[8*k +: 8]});
            step();
        end
        @(negedge clk);
        check("wr_done", {31'b0, mem_wr}, 32'd0);
        check("wr_idle", {31'b0, mem_busy}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        lsb2mem_load_en = 1'b0; lsb2mem_store_en = 1'b0; lsb2mem_addr = '0;
        lsb2mem_type = '0; lsb2mem_val = '0; lsb2mem_load_id = '0;
        step(); step();
        @(negedge clk);
        check("rst_busy", {31'b0, mem_busy}, 32'd0);
        check("rst_a", mem_a, 32'd0);
        check("rst_wr", {31'b0, mem_wr}, 32'd0);
        check("rst_load_en", {31'b0, mem2lsb_load_en}, 32'd0);
        step();
        rst_in = 1'b1;
        step();

        // Word, byte/half with sign and zero extension, address wrap
        send_load(32'h100, T_W, 3'd3);         expect_load(32'h100, 4, 3'd3, 32'h44332211);
        send_load(32'h5, T_B, 3'd1);           expect_load(32'h5, 1, 3'd1, 32'hFFFFFF80);
        send_load(32'h5, T_BU, 3'd2);          expect_load(32'h5, 1, 3'd2, 32'h00000080);
        send_load(32'h6, T_HU, 3'd7);          expect_load(32'h6, 2, 3'd7, 32'h00009234);
        send_load(32'h6, T_H, 3'd0);           expect_load(32'h6, 2, 3'd0, 32'hFFFF9234);
        send_load(32'hFFFFFFFF, T_H, 3'd6);    expect_load(32'hFFFFFFFF, 2, 3'd6, 32'hFFFFA55A);

        // Stores: halfword, then word crossing the address wrap
        send_store(32'h200, T_H, 32'hDEADBEEF); expect_store(32'h200, 2, 32'hDEADBEEF);
        send_store(32'hFFFFFFFE, T_W, 32'h01020304); expect_store(32'hFFFFFFFE, 4, 32'h01020304);

        // Store arrives during the 2nd byte of a load and waits in the slot
        send_load(32'h100, T_W, 3'd5);
        step();
        @(negedge clk);
        check("ps_addr1", mem_a, 32'h101);
        send_store(32'h3FC, T_W, 32'hA1B2C3D4);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("ps_busy", {31'b0, mem_busy}, 32'd1);
            check("ps_addr", mem_a, 32'h102 + 32'(k));
            step();
        end
        @(negedge clk);
        check("ps_busy_e5", {31'b0, mem_busy}, 32'd1);
        check("ps_early", {31'b0, mem2lsb_load_en}, 32'd0);
        step();
        @(negedge clk);
        check("ps_pulse", {31'b0, mem2lsb_load_en}, 32'd1);
        check("ps_val", mem2lsb_load_val, 32'h44332211);
        check("ps_id", {29'b0, mem2lsb_load_id}, 32'd5);
        check("ps_busy_e6", {31'b0, mem_busy}, 32'd1);
        step();
        expect_store(32'h3FC, 4, 32'hA1B2C3D4);

        // Flush aborts a read but not a committed write
        send_load(32'h100, T_W, 3'd4);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        check("fl_idle", {31'b0, mem_busy}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem2lsb_load_en) seen = 1'b1;
            step();
        end
        check("fl_no_pulse", {31'b0, seen}, 32'd0);

        send_store(32'h220, T_W, 32'hCAFEF00D);
        @(negedge clk);
        check("flw_b0", {mem_a[23:0], mem_dout}, 32'h00022_00D);
        step();
        flush = 1'b1;
        @(negedge clk);
        check("flw_b1", {mem_a[23:0], mem_dout}, 32'h000221F0);
        check("flw_wr1", {31'b0, mem_wr}, 32'd1);
        step();
        flush = 1'b0;
        @(negedge clk);
        check("flw_b2", {mem_a[23:0], mem_dout}, 32'h000222FE);
        step();
        @(negedge clk);
        check("flw_b3", {mem_a[23:0], mem_dout}, 32'h000223CA);
        check("flw_wr3", {31'b0, mem_wr}, 32'd1);
        step();
        @(negedge clk);
        check("flw_done", {31'b0, mem_busy}, 32'd0);

        // Flush in the response cycle suppresses the pulse
        send_load(32'h5, T_B, 3'd2);
        step();
        step();
        flush = 1'b1;
        @(negedge clk);
        check("flr_pulse", {31'b0, mem2lsb_load_en}, 32'd0);
        step();
        flush = 1'b0;
        @(negedge clk);
        check("flr_after", {31'b0, mem2lsb_load_en}, 32'd0);

        // Freeze mid-read: lost byte is re-issued, result still correct
        send_load(32'h100, T_W, 3'd4);
        step();
        step();
        rdy_in = 1'b0;
        step();
        step();
        rdy_in = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (mem2lsb_load_en) begin
                seen = 1'b1;
                check("rdy_val", mem2lsb_load_val, 32'h44332211);
                check("rdy_id", {29'b0, mem2lsb_load_id}, 32'd4);
            end
            step();
        end
        check("rdy_pulse_seen", {31'b0, seen}, 32'd1);

        // Freeze mid-write: mem_wr forced low, byte written on return
        send_store(32'h210, T_H, 32'h0000A1B2);
        @(negedge clk);
        check("rdw_b0", {mem_a[23:0], mem_dout}, 32'h000210B2);
        step();
        rdy_in = 1'b0;
        @(negedge clk);
        check("rdw_frozen_wr", {31'b0, mem_wr}, 32'd0);
        step();
        rdy_in = 1'b1;
        @(negedge clk);
        check("rdw_b1", {mem_a[23:0], mem_dout}, 32'h000211A1);
        check("rdw_wr1", {31'b0, mem_wr}, 32'd1);
        step();
        @(negedge clk);
        check("rdw_done", {31'b0, mem_busy}, 32'd0);

        // IO-space write while the UART buffer is full
        io_buffer_full = 1'b1;
        send_store(32'h30000, T_B, 32'h00000077);
`ifdef LSB_MEM_CTRL_IO_STALL_EN
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("io_stall_wr", {31'b0, mem_wr}, 32'd0);
            check("io_stall_a", mem_a, 32'h30000);
            step();
        end
        io_buffer_full = 1'b0;
        expect_store(32'h30000, 1, 32'h00000077);
`else
        expect_store(32'h30000, 1, 32'h00000077);
        io_buffer_full = 1'b0;
`endif

        // Async reset in the middle of a read
        send_load(32'h100, T_W, 3'd6);
        step();
        #2;
        rst_in = 1'b0;
        #1;
        check("ar_busy", {31'b0, mem_busy}, 32'd0);
        check("ar_a", mem_a, 32'd0);
        check("ar_dout", {24'b0, mem_dout}, 32'd0);
        check("ar_wr", {31'b0, mem_wr}, 32'd0);
        check("ar_id", {29'b0, mem2lsb_load_id}, 32'd0);
        check("ar_val", mem2lsb_load_val, 32'd0);
        check("ar_load_en", {31'b0, mem2lsb_load_en}, 32'd0);
        step();
        step();
        rst_in = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mem2lsb_load_en || mem_busy) seen = 1'b1;
            step();
        end
        check("ar_quiet", {31'b0, seen}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
